ysyx_dmem_resp: RTL and testbench
=================================

YSYX_DMEM_RESP -- requirements
Module: ysyx_dmem_resp

Interface
REQ-001 SHALL have parameter BASE, default 32'h8000_0000, meaning byte address of word 0.
REQ-002 SHALL have parameter DEPTH, default 1024, meaning number of 32-bit words (power of two).
REQ-003 SHALL have parameter RD_LAT, default 2, meaning wait cycles before a read response (1..15).
REQ-004 SHALL have parameter WR_LAT, default 1, meaning wait cycles before a write response (1..15).
REQ-005 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-006 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-007 SHALL have port req_valid  input  1  initiator presents request.
REQ-008 SHALL have port req_ready  output  1  responder accepts request this cycle.
REQ-009 SHALL have port req_we  input  1  1 = write, 0 = read.
REQ-010 SHALL have port req_addr  input  32  byte address; bits [1:0] ignored.
REQ-011 SHALL have port req_wdata  input  32  write data, lane-aligned.
REQ-012 SHALL have port req_wstrb  input  4  byte-lane write enables.
REQ-013 SHALL have port resp_valid  output  1  response available.
REQ-014 SHALL have port resp_ready  input  1  initiator accepts response.
REQ-015 SHALL have port resp_rdata  output  32  read word; 0 for writes and errors.
REQ-016 SHALL have port resp_err  output  1  address out of range.

Function
REQ-017 SHALL implement FSM states IDLE, WAIT, RESP.
REQ-018 SHALL drive req_ready = 1 only in IDLE; resp_valid = 1 only in RESP.
REQ-019 SHALL, on req_valid & req_ready, latch we/addr/wdata/wstrb, load down-counter with RD_LAT or WR_LAT, go WAIT.
REQ-020 SHALL decrement the counter each WAIT cycle; at counter==1 transition to RESP on the next edge.
REQ-021 SHALL give latency: request handshake at edge N -> resp_valid first high in cycle after edge N+LAT.
REQ-022 SHALL, on the edge entering RESP, commit the write (lanes with wstrb bit set only) or capture the read word into resp_rdata.
REQ-023 SHALL hold resp_valid, resp_rdata, resp_err stable in RESP until resp_ready is sampled high, then go IDLE.
REQ-024 SHALL NOT accept a new request in the cycle the response handshakes; next acceptance is earliest one cycle later.
REQ-025 SHALL flag resp_err = 1 when addr < BASE or addr >= BASE + 4*DEPTH; such a write modifies nothing, such a read returns 0.
REQ-026 SHALL index the array by (addr - BASE)[log2(DEPTH)+1:2].
REQ-027 SHALL treat req_wstrb = 0 write as a legal no-op with resp_err = 0.
REQ-028 SHALL ignore req_wdata/req_wstrb for reads, and ignore all req_* inputs outside IDLE.
REQ-029 SHALL make a read following a write to the same word return the newly written data.

Reset
REQ-030 SHALL, on rst high, immediately force IDLE, req_ready = 1 after deassertion, resp_valid = 0, resp_rdata = 0, resp_err = 0, counter = 0.
REQ-031 SHALL abandon any in-flight request on reset mid-operation; an uncommitted write is not performed.
REQ-032 SHALL NOT reset memory array contents.

Structure
REQ-033 SHALL place the state enum, counter width (4) and default BASE/DEPTH constants in package ysyx_dmem_pkg.
REQ-034 SHALL implement storage in sub-module ysyx_dmem_array (one synchronous write port with 4 byte enables, one read port).

Verification
REQ-035 SHALL test: write 0xDEADBEEF strb 4'b1111 to 0x8000_0010, then read it -> resp_rdata = 0xDEADBEEF, resp_err = 0, read resp_valid 2 cycles after handshake.
REQ-036 SHALL test: write 0x0000_AA00 strb 4'b0010 over 0x11223344 -> readback 0x1122AA44.
REQ-037 SHALL test: read 0x7FFF_FFFC and write 0x8000_1000 (DEPTH=1024) -> resp_err = 1, rdata = 0, memory unchanged.
REQ-038 SHALL test: hold resp_ready = 0 for 5 cycles in RESP -> resp_valid/rdata stable, req_ready = 0 throughout.
REQ-039 SHALL test: assert rst during WAIT of a write of 0x12345678 -> outputs reset immediately, subsequent read returns prior value.
REQ-040 SHALL test: back-to-back requests with req_valid held high -> one acceptance per WR_LAT+2 or RD_LAT+2 cycles, no dropped or duplicated responses.

Source files
------------

// File: rtl/ysyx_dmem_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ysyx_dmem_pkg
//  Description : Shared types and constants for the ysyx data-memory responder.
//                Holds the FSM state encoding, the latency counter width and
//                the default address map.
//  Revision    : 1.0 - initial release
// ============================================================================
package ysyx_dmem_pkg;

    localparam int          CNT_W         = 4;
    localparam logic [31:0] DEFAULT_BASE  = 32'h8000_0000;
    localparam int          DEFAULT_DEPTH = 1024;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

endpackage : ysyx_dmem_pkg
`default_nettype wire

// File: rtl/ysyx_dmem_array.sv
`default_nettype none
// ============================================================================
//  Module      : ysyx_dmem_array
//  Description : Word-organised storage, one synchronous write port with four
//                byte-lane enables and one asynchronous read port sharing the
//                same address. Contents are never reset.
//  Ports       : clk      - write clock
//                we_i     - write enable
//                be_i     - byte-lane enables (bit n -> bits 8n+7:8n)
//                addr_i   - word index
//                wdata_i  - write word
//                rdata_o  - word currently stored at addr_i
//  Revision    : 1.0 - initial release
// ============================================================================
module ysyx_dmem_array #(
    parameter int DEPTH = 1024,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we_i,
    input  logic [3:0]    be_i,
    input  logic [AW-1:0] addr_i,
    input  logic [31:0]   wdata_i,
    output logic [31:0]   rdata_o
);

    logic [31:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we_i) begin
            for (int b = 0; b < 4; b++) begin
                if (be_i[b]) begin
                    mem_q[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
                end
            end
        end
    end

    assign rdata_o = mem_q[addr_i];

endmodule : ysyx_dmem_array
`default_nettype wire

// File: rtl/ysyx_dmem_resp.sv
`default_nettype none
// ============================================================================
//  Module      : ysyx_dmem_resp
//  Description : Single-outstanding data-memory responder. Accepts one request
//                in IDLE, waits a fixed read/write latency, then presents the
//                response until the initiator takes it.
//  Ports       : clk, rst                  - clock, async active-high reset
//                req_valid/req_ready       - request handshake
//                req_we/addr/wdata/wstrb   - request payload
//                resp_valid/resp_ready     - response handshake
//                resp_rdata/resp_err       - response payload
//  Revision    : 1.0 - initial release
// ============================================================================
module ysyx_dmem_resp
    import ysyx_dmem_pkg::*;
#(
    parameter logic [31:0] BASE   = DEFAULT_BASE,
    parameter int          DEPTH  = DEFAULT_DEPTH,
    parameter int          RD_LAT = 2,
    parameter int          WR_LAT = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_wstrb,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);

    localparam int               AW       = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] RD_CNT   = CNT_W'(RD_LAT);
    localparam logic [CNT_W-1:0] WR_CNT   = CNT_W'(WR_LAT);
    // One past the last valid byte; 33 bits so a map ending at 4 GiB is exact.
    localparam logic [32:0]      END_ADDR = {1'b0, BASE} + 33'(4 * DEPTH);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             we_q;
    logic [31:0]      addr_q;
    logic [31:0]      wdata_q;
    logic [3:0]       wstrb_q;
    logic [31:0]      rdata_q;
    logic             err_q;

    logic             accept;
    logic             enter_resp;
    logic             oob;
    logic [AW-1:0]    word_idx;
    logic             arr_we;
    logic [31:0]      arr_rdata;

    assign req_ready  = (state_q == ST_IDLE);
    assign resp_valid = (state_q == ST_RESP);
    assign resp_rdata = rdata_q;
    assign resp_err   = err_q;

    assign accept     = req_valid & req_ready;
    assign enter_resp = (state_q == ST_WAIT) && (cnt_q <= CNT_W'(1));

    assign oob      = ({1'b0, addr_q} < {1'b0, BASE}) || ({1'b0, addr_q} >= END_ADDR);
    // BASE is word aligned, so only the word-index bits take part in the offset.
    assign word_idx = addr_q[AW+1:2] - BASE[AW+1:2];

    // The write lands on the same edge the FSM enters RESP; a reset before that
    // edge returns the FSM to IDLE and the write never happens.
    assign arr_we = enter_resp & we_q & ~oob;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d = ST_WAIT;
                    cnt_d   = req_we ? WR_CNT : RD_CNT;
                end
            end
            ST_WAIT: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q <= CNT_W'(1)) begin
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                if (resp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            wstrb_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                we_q    <= req_we;
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
                wstrb_q <= req_wstrb;
            end
            // Response payload is captured once and then held for all of RESP.
            if (enter_resp) begin
                err_q   <= oob;
                rdata_q <= (we_q || oob) ? 32'h0 : arr_rdata;
            end
        end
    end

    ysyx_dmem_array #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_array (
        .clk     (clk),
        .we_i    (arr_we),
        .be_i    (wstrb_q),
        .addr_i  (word_idx),
        .wdata_i (wdata_q),
        .rdata_o (arr_rdata)
    );

endmodule : ysyx_dmem_resp
`default_nettype wire

// File: tb/tb_ysyx_dmem_resp.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ysyx_dmem_resp
//  Description : Self-checking bench for ysyx_dmem_resp. Directed scenarios
//                plus randomized single and back-to-back transactions,
//                compared against a word-level memory model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ysyx_dmem_resp;

    localparam logic [31:0] BASE    = 32'h8000_0000;
    localparam int          DEPTH   = 1024;
    localparam int          RD_LAT  = 2;
    localparam int          WR_LAT  = 1;
    localparam int          REGION  = 64;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic [3:0]  req_wstrb = '0;
    logic        resp_valid;
    logic        resp_ready = 1'b0;
    logic [31:0] resp_rdata;
    logic        resp_err;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    logic [31:0] model_mem [int];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    ysyx_dmem_resp #(
        .BASE   (BASE),
        .DEPTH  (DEPTH),
        .RD_LAT (RD_LAT),
        .WR_LAT (WR_LAT)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_wstrb  (req_wstrb),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err)
    );

    task automatic check32(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    function automatic bit in_range(input logic [31:0] a);
        return ({1'b0, a} >= {1'b0, BASE}) && ({1'b0, a} < ({1'b0, BASE} + 33'(4 * DEPTH)));
    endfunction

    // Reference behaviour: byte-lane merge into a word-addressed model.
    task automatic model_apply(input bit we, input logic [31:0] a, input logic [31:0] wd,
                               input logic [3:0] st, output logic [31:0] exp_rd,
                               output bit exp_err);
        int          k;
        logic [31:0] w;
        exp_rd  = 32'h0;
        exp_err = !in_range(a);
        if (!exp_err) begin
            k = int'((a - BASE) / 4);
            if (we) begin
                w = model_mem.exists(k) ? model_mem[k] : 32'hx;
                for (int b = 0; b < 4; b++)
                    if (st[b]) w[8*b +: 8] = wd[8*b +: 8];
                model_mem[k] = w;
            end else begin
                exp_rd = model_mem.exists(k) ? model_mem[k] : 32'hx;
            end
        end
    endtask

    function automatic logic [31:0] rand_addr();
        int r;
        r = $urandom_range(0, 7);
        if (r < 6)       return BASE + 32'($urandom_range(0, REGION-1) * 4) + 32'($urandom_range(0, 3));
        else if (r == 6) return BASE - 32'(4 * $urandom_range(1, 16));
        else             return BASE + 32'(4 * DEPTH) + 32'($urandom_range(0, 63));
    endfunction

    task automatic wait_ready(input string tag);
        int w = 0;
        while (!req_ready && w < 50) begin
            @(posedge clk); #1; w++;
        end
        check32({tag, " ready"}, {31'b0, req_ready}, 32'd1);
    endtask

    // One full transaction: handshake, latency, hold in RESP, release.
    task automatic txn(input bit we, input logic [31:0] a, input logic [31:0] wd,
                       input logic [3:0] st, input int hold, input string tag);
        logic [31:0] exp_rd;
        bit          exp_err;
        int          lat;
        wait_ready(tag);
        req_valid = 1'b1; req_we = we; req_addr = a; req_wdata = wd; req_wstrb = st;
        model_apply(we, a, wd, st, exp_rd, exp_err);
        @(posedge clk); #1;
        // Inputs outside IDLE must be ignored: drive garbage.
        req_valid = 1'($urandom); req_we = 1'($urandom); req_addr = $urandom;
        req_wdata = $urandom; req_wstrb = 4'($urandom);
        lat = 0;
        while (!resp_valid && lat < 40) begin
            @(posedge clk); #1; lat++;
        end
        check32({tag, " lat"}, 32'(lat), 32'(we ? WR_LAT : RD_LAT));
        check32({tag, " rdata"}, resp_rdata, exp_rd);
        check32({tag, " err"}, {31'b0, resp_err}, {31'b0, exp_err});
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            check32({tag, " hold valid"}, {31'b0, resp_valid}, 32'd1);
            check32({tag, " hold rdata"}, resp_rdata, exp_rd);
            check32({tag, " hold err"}, {31'b0, resp_err}, {31'b0, exp_err});
            check32({tag, " hold ready"}, {31'b0, req_ready}, 32'd0);
        end
        resp_ready = 1'b1;
        @(posedge clk); #1;
        resp_ready = 1'b0;
        req_valid  = 1'b0;
        check32({tag, " done valid"}, {31'b0, resp_valid}, 32'd0);
        check32({tag, " done ready"}, {31'b0, req_ready}, 32'd1);
    endtask

    // Requests with req_valid and resp_ready held high throughout.
    task automatic b2b(input int n);
        logic [31:0] exp_rd, a, wd;
        logic [3:0]  st;
        bit          exp_err, we;
        int          hs, prev_hs, prev_lat, lat, n_resp;
        prev_hs = -1; prev_lat = 0; n_resp = 0;
        resp_ready = 1'b1;
        req_valid  = 1'b1;
        for (int k = 0; k < n; k++) begin
            we = 1'($urandom); a = rand_addr(); wd = $urandom; st = 4'($urandom);
            req_we = we; req_addr = a; req_wdata = wd; req_wstrb = st;
            wait_ready("b2b");
            hs = cyc + 1;
            if (prev_hs >= 0)
                check32("b2b spacing", 32'(hs - prev_hs), 32'(prev_lat + 2));
            prev_hs  = hs;
            prev_lat = we ? WR_LAT : RD_LAT;
            model_apply(we, a, wd, st, exp_rd, exp_err);
            @(posedge clk); #1;
            req_we = 1'($urandom); req_addr = $urandom; req_wdata = $urandom;
            lat = 0;
            while (!resp_valid && lat < 40) begin
                @(posedge clk); #1; lat++;
            end
            if (resp_valid) n_resp++;
            check32("b2b lat", 32'(lat), 32'(prev_lat));
            check32("b2b rdata", resp_rdata, exp_rd);
            check32("b2b err", {31'b0, resp_err}, {31'b0, exp_err});
        end
        req_valid = 1'b0;
        @(posedge clk); #1;
        resp_ready = 1'b0;
        check32("b2b resp count", 32'(n_resp), 32'(n));
        check32("b2b no dup", {31'b0, resp_valid}, 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [31:0] exp_rd;
        bit          exp_err;
        int          w;

        repeat (2) @(posedge clk);
        #1;
        check32("reset valid", {31'b0, resp_valid}, 32'd0);
        check32("reset rdata", resp_rdata, 32'h0);
        check32("reset err", {31'b0, resp_err}, 32'd0);
        rst = 1'b0;
        #1;
        check32("reset ready", {31'b0, req_ready}, 32'd1);

        // Known contents for the test region and the last word.
        for (int i = 0; i < REGION; i++)
            txn(1'b1, BASE + 32'(4 * i), $urandom, 4'hF, 0, "fill");
        txn(1'b1, BASE + 32'(4 * (DEPTH - 1)), 32'hA5A5_5A5A, 4'hF, 0, "fill last");

        txn(1'b1, 32'h8000_0010, 32'hDEAD_BEEF, 4'hF, 0, "wr beef");
        txn(1'b0, 32'h8000_0010, 32'h0, 4'h0, 0, "rd beef");

        txn(1'b1, 32'h8000_0020, 32'h1122_3344, 4'hF, 0, "wr base");
        txn(1'b1, 32'h8000_0020, 32'h0000_AA00, 4'b0010, 0, "wr lane1");
        txn(1'b0, 32'h8000_0020, 32'h0, 4'h0, 0, "rd lane1");
        check32("lane merge model", model_mem[8], 32'h1122_AA44);

        txn(1'b0, 32'h7FFF_FFFC, 32'h0, 4'h0, 0, "rd below");
        txn(1'b1, 32'h8000_1000, 32'hCAFE_F00D, 4'hF, 0, "wr above");
        txn(1'b0, 32'h8000_0000, 32'h0, 4'h0, 0, "rd word0");
        txn(1'b0, 32'h8000_0FFC, 32'h0, 4'h0, 0, "rd last");
        txn(1'b1, 32'h8000_0014, 32'hFFFF_FFFF, 4'h0, 0, "wr nostrb");
        txn(1'b0, 32'h8000_0014, 32'h0, 4'h0, 0, "rd nostrb");

        txn(1'b0, 32'h8000_0010, 32'h0, 4'h0, 5, "rd hold");

        // Reset in WAIT of a write: resp_rdata still holds the previous read.
        wait_ready("rst wr");
        req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h8000_0010;
        req_wdata = 32'h1234_5678; req_wstrb = 4'hF;
        @(posedge clk); #1;
        req_valid = 1'b0;
        check32("pre-rst rdata", resp_rdata, 32'hDEAD_BEEF);
        rst = 1'b1;
        #1;
        check32("rst valid", {31'b0, resp_valid}, 32'd0);
        check32("rst rdata", resp_rdata, 32'h0);
        check32("rst err", {31'b0, resp_err}, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check32("post-rst ready", {31'b0, req_ready}, 32'd1);
        txn(1'b0, 32'h8000_0010, 32'h0, 4'h0, 0, "rd after rst");

        for (int i = 0; i < 150; i++)
            txn(1'($urandom), rand_addr(), $urandom, 4'($urandom),
                $urandom_range(0, 3), "rand");

        b2b(30);

        w = 0;
        while (!req_ready && w < 10) begin
            @(posedge clk); #1; w++;
        end
        check32("final idle", {31'b0, req_ready}, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule : tb_ysyx_dmem_resp
`default_nettype wire
